// File: rtl/ps2_pkg.sv
// Scan-code constants and prefix FSM encodings shared by the PS/2 receiver and decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Saturating cycle counter that flags when a prefix state has waited too long.
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (run && (count != LAST))
      count <= count + CNT_W'(1);
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 scan-code bytes into held-key levels for game control, with prefix timeout.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       pause,
  output logic       frame_err
);

  ps2_state_t state, state_d;
  logic pressed_q, armed, accept, expired;
  logic left_ext, a_held, right_ext, d_held, space_held, p_held, pause_q;
  logic left_ext_d, a_held_d, right_ext_d, d_held_d, space_held_d, p_held_d, pause_d;
  logic frame_err_q, frame_err_d, move_left_q, move_right_q;
  logic left_any_d, right_any_d;

  // armed blocks an accept in the first cycle after reset if the flag is already high
  assign accept = armed && ps2_key_pressed && !pressed_q;

  ps2_prefix_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .clear    (accept || (state == ST_IDLE)),
    .run      (state != ST_IDLE),
    .expired  (expired)
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state        <= ST_IDLE;
      pressed_q    <= 1'b0;
      armed        <= 1'b0;
      left_ext     <= 1'b0;
      a_held       <= 1'b0;
      right_ext    <= 1'b0;
      d_held       <= 1'b0;
      space_held   <= 1'b0;
      p_held       <= 1'b0;
      pause_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
    end else begin
      state        <= state_d;
      pressed_q    <= ps2_key_pressed;
      armed        <= 1'b1;
      left_ext     <= left_ext_d;
      a_held       <= a_held_d;
      right_ext    <= right_ext_d;
      d_held       <= d_held_d;
      space_held   <= space_held_d;
      p_held       <= p_held_d;
      pause_q      <= pause_d;
      frame_err_q  <= frame_err_d;
      move_left_q  <= left_any_d && !right_any_d;
      move_right_q <= right_any_d && !left_any_d;
    end
  end

  always_comb begin
    state_d      = state;
    left_ext_d   = left_ext;
    a_held_d     = a_held;
    right_ext_d  = right_ext;
    d_held_d     = d_held;
    space_held_d = space_held;
    p_held_d     = p_held;
    pause_d      = pause_q;
    frame_err_d  = 1'b0;

    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (ps2_key_data == SC_EXT)
            state_d = ST_EXT;
          else if (ps2_key_data == SC_BRK)
            state_d = ST_BRK;
          else begin
            case (ps2_key_data)
              SC_A:     a_held_d     = 1'b1;
              SC_D:     d_held_d     = 1'b1;
              SC_SPACE: space_held_d = 1'b1;
              SC_P: begin
                // typematic repeats arrive with p_held already set
                if (!p_held)
                  pause_d = !pause_q;
                p_held_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_EXT: begin
          if (ps2_key_data == SC_BRK)
            state_d = ST_EXT_BRK;
          else begin
            state_d = ST_IDLE;
            if (ps2_key_data == SC_LEFT)
              left_ext_d = 1'b1;
            else if (ps2_key_data == SC_RIGHT)
              right_ext_d = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (is_prefix(ps2_key_data))
            frame_err_d = 1'b1;
          else begin
            case (ps2_key_data)
              SC_A:     a_held_d     = 1'b0;
              SC_D:     d_held_d     = 1'b0;
              SC_SPACE: space_held_d = 1'b0;
              SC_P:     p_held_d     = 1'b0;
              default: ;
            endcase
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (is_prefix(ps2_key_data))
            frame_err_d = 1'b1;
          else if (ps2_key_data == SC_LEFT)
            left_ext_d = 1'b0;
          else if (ps2_key_data == SC_RIGHT)
            right_ext_d = 1'b0;
        end
      endcase
    end else if (expired) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end

    left_any_d  = left_ext_d || a_held_d;
    right_any_d = right_ext_d || d_held_d;
  end

  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign fire       = space_held;
  assign pause      = pause_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 2500000, is the number of clocks a prefix state may wait for its next byte before aborting (100 ms at 25 MHz).
REQ-002 Port iVGA_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port iRST_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port ps2_key_data, input, 8 bits: last scan-code byte from the PS/2 receiver.
REQ-005 Port ps2_key_pressed, input, 1 bit: byte-valid flag from the PS/2 receiver; a rising edge marks one new byte.
REQ-006 Port move_left, output, 1 bit: level, high while a left key is held and right is not.
REQ-007 Port move_right, output, 1 bit: level, high while a right key is held and left is not.
REQ-008 Port fire, output, 1 bit: level, high while Space is held.
REQ-009 Port pause, output, 1 bit: toggle state, inverted on each fresh P make.
REQ-010 Port frame_err, output, 1 bit: one-cycle pulse on prefix timeout or on an illegal byte sequence.

Function
REQ-011 Byte accept: a byte is accepted on the first cycle where ps2_key_pressed is 1 and its registered previous value is 0; a held-high flag yields exactly one accept.
REQ-012 The FSM has 4 states: IDLE, EXT (after E0), BRK (after F0), and EXT_BRK (after E0 F0).
REQ-013 Transitions from IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a make and stays in IDLE.
REQ-014 Transitions from EXT: F0 goes to EXT_BRK; other bytes are an extended make and return to IDLE.
REQ-015 Transitions from BRK or EXT_BRK: any byte is a break and returns to IDLE; E0 or F0 received here returns to IDLE and pulses frame_err.
REQ-016 Key map (make sets the held bit, break clears it): Left is E0 6B and A is 1C (left); Right is E0 74 and D is 23 (right); Space is 29 (fire); P is 4D (pause).
REQ-017 Unmapped codes change no held bit.
REQ-018 Non-extended 6B and 74 (keypad) are unmapped.
REQ-019 Outputs: move_left = left_held AND NOT right_held; move_right = right_held AND NOT left_held; when both are held, both outputs are 0.
REQ-020 Left and A are tracked separately; left_held = Left OR A, and likewise for right.
REQ-021 Pause toggles only on a P make when p_held is 0; typematic repeats of 4D do not toggle; a P break clears p_held.
REQ-022 Timeout: a counter clears on entry to EXT, BRK or EXT_BRK and increments each cycle while in those states.
REQ-023 When the counter reaches TIMEOUT_CYC-1 with no accept, the FSM returns to IDLE and pulses frame_err.
REQ-024 A timeout changes no held bit.
REQ-025 If an accept and the timeout occur in the same cycle, the accept wins.
REQ-026 Latency: all outputs are registered and reflect a byte exactly 1 cycle after its accept cycle.
REQ-027 The counter width is clog2(TIMEOUT_CYC), and the counter saturates rather than wraps.

Reset
REQ-028 Asserting iRST_n low immediately sets the FSM to IDLE and clears all held bits, pause, frame_err, the counter and the edge register, including mid-sequence.
REQ-029 Reset release is synchronised to iVGA_CLK by the consumer; no byte is accepted in the first cycle after release if ps2_key_pressed is already high.

Structure
REQ-030 The scan-code constants (E0, F0, 6B, 74, 1C, 23, 29, 4D) and the FSM state encodings shall live in a shared package, ps2_pkg, used by the receiver and the decoder.
REQ-031 The decoder is one module; the optional sub-module ps2_prefix_timer shall hold the counter and compare.

Verification
REQ-032 Reset, then bytes E0 6B: move_left = 1 one cycle after the 6B accept; then E0 F0 6B: move_left = 0.
REQ-033 Hold A (1C), then make D (23): move_left and move_right both 0; then break A (F0 1C): move_right = 1.
REQ-034 Send 4D three times (typematic), then F0 4D, then 4D: pause toggles 0 to 1 once, then 1 to 0 on the second fresh make.
REQ-035 Send E0, then idle for TIMEOUT_CYC cycles (TIMEOUT_CYC = 16 in the bench): frame_err pulses for 1 cycle at count 15, the FSM is in IDLE, and a following 29 sets fire = 1.
REQ-036 Hold ps2_key_pressed high for 5 cycles with 29: exactly one accept, and fire = 1.
REQ-037 Send F0 then assert iRST_n low mid-sequence: all outputs 0 asynchronously; after release, 29 is treated as a make and fire = 1.
